// File: rtl/encoder_83.sv
// rtl/encoder_83.sv - registered 8-to-3 priority encoder with enable, valid and optional multi-request flag (ENCODER_83_MULTI_DET_EN)
module encoder_83 (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic in7,
    input  logic in6,
    input  logic in5,
    input  logic in4,
    input  logic in3,
    input  logic in2,
    input  logic in1,
    input  logic in0,
    output logic Q2,
    output logic Q1,
    output logic Q0,
`ifdef ENCODER_83_MULTI_DET_EN
    output logic V,
    output logic M
`else
    output logic V
`endif
);

    logic [7:0] req;
    logic [2:0] idx_d, idx_q;
    logic       vld_d, vld_q;

    assign req = {in7, in6, in5, in4, in3, in2, in1, in0};

    // Priority encode: in7 wins; gated requests and an empty vector both give index 0, not valid.
    always_comb begin
        idx_d = 3'd0;
        vld_d = 1'b0;
        if (en) begin
            vld_d = |req;
            casez (req)
                8'b1???????: idx_d = 3'd7;
                8'b01??????: idx_d = 3'd6;
                8'b001?????: idx_d = 3'd5;
                8'b0001????: idx_d = 3'd4;
                8'b00001???: idx_d = 3'd3;
                8'b000001??: idx_d = 3'd2;
                8'b0000001?: idx_d = 3'd1;
                default:     idx_d = 3'd0;
            endcase
        end
    end

    // Output registers; reset overrides enable and inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= 3'd0;
            vld_q <= 1'b0;
        end else begin
            idx_q <= idx_d;
            vld_q <= vld_d;
        end
    end

    assign Q2 = idx_q[2];
    assign Q1 = idx_q[1];
    assign Q0 = idx_q[0];
    assign V  = vld_q;

`ifdef ENCODER_83_MULTI_DET_EN
    logic multi_d, multi_q;

    // Clearing the lowest set bit leaves something only when two or more requests are set.
    always_comb begin
        multi_d = 1'b0;
        if (en) begin
            multi_d = |(req & (req - 8'd1));
        end
    end

    // Multi-request flag register, same reset and timing as the index.
    always_ff @(posedge clk) begin
        if (rst) begin
            multi_q <= 1'b0;
        end else begin
            multi_q <= multi_d;
        end
    end

    assign M = multi_q;
`endif

endmodule

// File: tb/tb_encoder_83.sv
// tb/tb_encoder_83.sv - scoreboard bench for encoder_83
module tb_encoder_83;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic [7:0] r;
    logic Q2, Q1, Q0, V;
    logic m_obs;

    int tests_run = 0;
    int tests_failed = 0;

    logic [4:0] exp_q[$];

    always #5 clk = ~clk;

`ifdef ENCODER_83_MULTI_DET_EN
    logic M;
    assign m_obs = M;
    encoder_83 dut (
        .clk(clk), .rst(rst), .en(en),
        .in7(r[7]), .in6(r[6]), .in5(r[5]), .in4(r[4]),
        .in3(r[3]), .in2(r[2]), .in1(r[1]), .in0(r[0]),
        .Q2(Q2), .Q1(Q1), .Q0(Q0), .V(V), .M(M)
    );
`else
    assign m_obs = 1'b0;
    encoder_83 dut (
        .clk(clk), .rst(rst), .en(en),
        .in7(r[7]), .in6(r[6]), .in5(r[5]), .in4(r[4]),
        .in3(r[3]), .in2(r[2]), .in1(r[1]), .in0(r[0]),
        .Q2(Q2), .Q1(Q1), .Q0(Q0), .V(V)
    );
`endif

    task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got Q=%b V=%b M=%b, expected Q=%b V=%b M=%b",
                     tag, got[4:2], got[1], got[0], exp[4:2], exp[1], exp[0]);
        end
    endtask

    // Reference: scan from the top for the first set bit; count bits for the multi flag.
    function automatic logic [4:0] model(input logic rst_m, input logic en_m, input logic [7:0] r_m);
        logic [2:0] idx;
        logic       v;
        logic       m;
        idx = 3'd0;
        v   = 1'b0;
        m   = 1'b0;
        if (!rst_m && en_m && r_m != 8'd0) begin
            v = 1'b1;
            for (int i = 7; i >= 0; i--) begin
                if (r_m[i]) begin
                    idx = 3'(i);
                    break;
                end
            end
`ifdef ENCODER_83_MULTI_DET_EN
            m = ($countones(r_m) >= 2);
`endif
        end
        return {idx, v, m};
    endfunction

    // Drive one cycle of stimulus, optionally glitching the request lines first, then compare after the edge.
    task automatic step(input string tag, input logic rst_s, input logic en_s,
                        input logic [7:0] r_s, input bit glitch);
        logic [4:0] exp;
        if (glitch) begin
            rst = 1'b0;
            en  = 1'b1;
            r   = ~r_s;
            #2;
        end
        rst = rst_s;
        en  = en_s;
        r   = r_s;
        exp_q.push_back(model(rst_s, en_s, r_s));
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            exp = exp_q.pop_front();
            check(tag, {Q2, Q1, Q0, V, m_obs}, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        r   = 8'hFF;
        @(posedge clk);
        #1;

        // Reset held with everything requesting, then release.
        step("reset0", 1'b1, 1'b1, 8'hFF, 1'b0);
        step("reset1", 1'b1, 1'b1, 8'hFF, 1'b0);
        step("release", 1'b0, 1'b1, 8'hFF, 1'b0);
        check("release_const", {Q2, Q1, Q0, V, m_obs},
`ifdef ENCODER_83_MULTI_DET_EN
              5'b111_1_1);
`else
              5'b111_1_0);
`endif

        // Enable gating sweep.
        for (int i = 0; i < 256; i++) step("gated", 1'b0, 1'b0, 8'(i), 1'b0);

        // Exhaustive priority sweep.
        for (int i = 0; i < 256; i++) step("sweep", 1'b0, 1'b1, 8'(i), 1'b0);

        // Boundary points against fixed values.
        step("r0", 1'b0, 1'b1, 8'h00, 1'b0);
        check("r0_const", {Q2, Q1, Q0, V}, 4'b000_0);
        step("r1", 1'b0, 1'b1, 8'h01, 1'b0);
        check("r1_const", {Q2, Q1, Q0, V}, 4'b000_1);
        step("r28", 1'b0, 1'b1, 8'b0010_1000, 1'b0);
        check("r28_const", {Q2, Q1, Q0, V}, 4'b101_1);
        step("r16", 1'b0, 1'b1, 8'b0001_0110, 1'b0);
        check("r16_const", {Q2, Q1, Q0, V}, 4'b100_1);

        // Single-hot walk.
        for (int i = 0; i < 8; i++) begin
            step("onehot", 1'b0, 1'b1, 8'(1 << i), 1'b0);
            check("onehot_idx", {1'b0, Q2, Q1, Q0, m_obs}, {1'b0, 3'(i), 1'b0});
        end

        // Latency and enable toggle.
        step("lat_en", 1'b0, 1'b1, 8'b0100_0000, 1'b0);
        check("lat_en_const", {Q2, Q1, Q0, V}, 4'b110_1);
        step("lat_dis", 1'b0, 1'b0, 8'b0100_0000, 1'b0);
        check("lat_dis_const", {Q2, Q1, Q0, V}, 4'b000_0);

        // Mid-operation reset and immediate resume.
        step("mid_run", 1'b0, 1'b1, 8'b0000_1100, 1'b0);
        step("mid_rst", 1'b1, 1'b1, 8'b0000_1100, 1'b0);
        step("mid_resume", 1'b0, 1'b1, 8'b0000_0100, 1'b0);

        // Glitches between edges are invisible.
        step("glitch_a", 1'b0, 1'b1, 8'b0000_0010, 1'b1);
        step("glitch_b", 1'b0, 1'b0, 8'b1000_0000, 1'b1);
        step("glitch_c", 1'b0, 1'b1, 8'b0000_0000, 1'b1);

        // Random mix including reset pulses.
        for (int i = 0; i < 200; i++)
            step("random", ($urandom_range(0, 15) == 0), 1'($urandom), 8'($urandom), 1'($urandom));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/encoder_83.md
# encoder_83

Registered 8-to-3 priority encoder with enable and valid flag. It converts eight request lines into the binary index of the highest-numbered active line. `in7` has the highest priority and `in0` the lowest. It sits between a bank of request/interrupt lines and downstream logic that consumes an index plus a valid bit once per clock.

## Interface
- Parameters: none.
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset, sampled on the rising edge of `clk`.
- `en` input 1: encoder enable; when low, the encoder reports no request.
- `in7` … `in0` input 1 each: request lines; `in7` highest priority, `in0` lowest.
- `Q2`, `Q1`, `Q0` output 1 each: registered encoded index, with `Q2` as the MSB.
- `V` output 1: registered valid flag; high when an enabled request is present.
- `M` output 1: registered multiple-request flag. This port exists only when `ENCODER_83_MULTI_DET_EN` is defined.
- Port order: `clk`, `rst`, `en`, `in7` … `in0`, `Q2`, `Q1`, `Q0`, `V`, then `M` if present.

## Operation
- Treat the request vector as r = {in7, in6, …, in0}.
- Next-state function, evaluated combinationally from the current inputs:
  - `en`=0: {Q2,Q1,Q0}=000, V=0, M=0, regardless of r.
  - `en`=1 and r=0: {Q2,Q1,Q0}=000, V=0, M=0.
  - `en`=1 and r≠0: {Q2,Q1,Q0}= index of the highest set bit of r, and V=1.
    - M=1 if two or more bits of r are set; otherwise M=0.
- Lower-priority lines are ignored whenever a higher line is set. Examples: r=1000_0001 → 111; r=0001_0110 → 100.
- Index 0 with V=1 (only `in0` set) must be distinguishable from "no request" (000 with V=0). Consumers must qualify Q with V.
- No unknown or don't-care output codes: every one of the 512 {en, r} combinations maps to exactly one defined output.
- No internal state other than the output registers, so there is no state machine.

## Timing
- Latency is one clock cycle. Inputs sampled at rising edge N appear on the outputs right after edge N and hold until edge N+1.
- Reset value of every output: Q2=Q1=Q0=0, V=0, M=0.
- Reset behaviour:
  - While `rst`=1 at a rising edge, the outputs load their reset values and the inputs are ignored.
  - Reset takes priority over `en`.
  - Deasserting `rst` mid-operation resumes normal encoding on the first edge where `rst`=0, with no extra delay.
- Outputs change only on rising edges of `clk`. There are no combinational paths from any input to any output.
- Input changes between edges, including glitches, have no effect until the next edge.
- Toggling `en` and r in the same cycle: the result follows the sampled values of both at that edge.

## Configuration
- Macro: `ENCODER_83_MULTI_DET_EN`.
- Defined:
  - Port `M` and its register are present.
  - M is computed as specified above; it is 0 on reset and whenever `en`=0.
- Undefined:
  - Port `M` and all its logic are absent.
  - The remaining ports and behaviour are bit-for-bit identical to the defined case.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with `en`=1 and r=1111_1111 → after each edge Q=000, V=0, M=0. Release `rst` → the next edge gives Q=111, V=1, M=1.
- Enable gating: `en`=0, sweep r through all 256 values, one per cycle → Q=000, V=0, M=0 on every cycle.
- Exhaustive priority: `en`=1, sweep r through 0…255, one per cycle → each output one cycle later equals the index of the highest set bit.
  - r=0 gives V=0; r=1 gives Q=000, V=1; r=0010_1000 gives Q=101; r=1111_1111 gives Q=111.
- Single-hot: `en`=1, r=0000_0001, then 0000_0010, … 1000_0000 → Q=000 through 111 in sequence, V=1, M=0 throughout.
- Latency and enable toggle: on cycle k, apply r=0100_0000 with `en`=1; on cycle k+1, set `en`=0 → after edge k, Q=110, V=1; after edge k+1, Q=000, V=0.
- Macro build check: compile without `ENCODER_83_MULTI_DET_EN` and rerun the exhaustive sweep → Q and V match the defined-macro build exactly, and no `M` port exists.
